// File: rtl/seg7_fmt_if.sv
// Peripheral bus bundle between the MSP430 CPU side and the seg7_fmt register window.
// The CPU side drives address, data, enable and byte write enables; the peripheral returns read data.
interface seg7_fmt_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (
        output per_addr, per_din, per_en, per_we,
        input  per_dout
    );

    modport slave (
        input  per_addr, per_din, per_en, per_we,
        output per_dout
    );
endinterface

// File: rtl/seg7_fmt.sv
// Formats a CPU-written 16-bit value into four active-low 7-segment bytes (hex or decimal via double-dabble).
// Build option SEG7_FMT_LZB_EN enables the leading-zero-blank control bit.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for a VALUE write
// S_HEX_LOAD | one cycle: map the four nibbles straight to segment bytes
// S_SHIFT    | 16 double-dabble iterations (add-3 then shift left)
// S_LOAD     | write formatted BCD digits (or dashes on overflow)
module seg7_fmt #(
    parameter logic [14:0] BASE_ADDR = 15'h0098
) (
    input  logic            mclk,
    input  logic            puc_rst,
    seg7_fmt_if.slave       per,
    output logic [7:0]      seg_d0,
    output logic [7:0]      seg_d1,
    output logic [7:0]      seg_d2,
    output logic [7:0]      seg_d3,
    output logic            seg_upd,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HEX_LOAD = 2'd1,
        S_SHIFT    = 2'd2,
        S_LOAD     = 2'd3
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    function automatic logic [7:0] seg_lut(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] dp_apply(input logic [7:0] s, input logic dp);
        return dp ? (s & 8'h7F) : s;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] val_q, val_d;
    logic        dec_q, dec_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  dp_l_q, dp_l_d;
    logic        ovf_q, ovf_d;
    logic [35:0] sh_q, sh_d;
    logic [35:0] sh_adj;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  seg0_q, seg0_d, seg1_q, seg1_d, seg2_q, seg2_d, seg3_q, seg3_d;
    logic        seg_upd_q, seg_upd_d;

    logic        reg_sel, val_wr, ctl_wr, rd_en;
    logic [15:0] val_wdata;
    logic [15:0] ctrl_rd;

`ifdef SEG7_FMT_LZB_EN
    logic lzb_q, lzb_d, lzb_l_q, lzb_l_d;

    always_comb begin
        lzb_d   = lzb_q;
        lzb_l_d = lzb_l_q;
        if (ctl_wr && per.per_we[0]) lzb_d = per.per_din[1];
        if (val_wr)                  lzb_l_d = lzb_q;
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            lzb_q   <= 1'b0;
            lzb_l_q <= 1'b0;
        end else begin
            lzb_q   <= lzb_d;
            lzb_l_q <= lzb_l_d;
        end
    end
`else
    logic lzb_q, lzb_l_q;
    assign lzb_q   = 1'b0;
    assign lzb_l_q = 1'b0;
`endif

    assign reg_sel = per.per_en && (per.per_addr[13:1] == BASE_ADDR[14:2]);
    assign val_wr  = reg_sel && !per.per_addr[0] && (per.per_we != 2'b00);
    assign ctl_wr  = reg_sel &&  per.per_addr[0] && (per.per_we != 2'b00);
    assign rd_en   = reg_sel && (per.per_we == 2'b00);

    assign val_wdata = {per.per_we[1] ? per.per_din[15:8] : val_q[15:8],
                        per.per_we[0] ? per.per_din[7:0]  : val_q[7:0]};

    assign busy    = (state_q != S_IDLE);
    assign ctrl_rd = {6'd0, ovf_q, busy, dp_q, 2'b00, lzb_q, dec_q};

    assign per.per_dout = rd_en ? (per.per_addr[0] ? ctrl_rd : val_q) : 16'h0000;

    assign seg_d0  = seg0_q;
    assign seg_d1  = seg1_q;
    assign seg_d2  = seg2_q;
    assign seg_d3  = seg3_q;
    assign seg_upd = seg_upd_q;

    // Software-visible registers; only the low CTRL byte holds writable bits.
    always_comb begin
        val_d = val_q;
        dec_d = dec_q;
        dp_d  = dp_q;
        if (val_wr) val_d = val_wdata;
        if (ctl_wr && per.per_we[0]) begin
            dec_d = per.per_din[0];
            dp_d  = per.per_din[7:4];
        end
    end

    always_comb begin
        sh_adj = sh_q;
        for (int i = 0; i < 5; i++) begin
            if (sh_q[16+4*i +: 4] > 4'd4) sh_adj[16+4*i +: 4] = sh_q[16+4*i +: 4] + 4'd3;
        end
    end

    // Decimal digit formatting from the finished BCD register.
    logic [3:0] bcd0, bcd1, bcd2, bcd3;
    logic       bcd_ovf, blank1, blank2, blank3;
    logic [7:0] dseg0, dseg1, dseg2, dseg3;

    always_comb begin
        bcd0    = sh_q[19:16];
        bcd1    = sh_q[23:20];
        bcd2    = sh_q[27:24];
        bcd3    = sh_q[31:28];
        bcd_ovf = (sh_q[35:32] != 4'd0);
        blank3  = lzb_l_q && (bcd3 == 4'd0);
        blank2  = blank3  && (bcd2 == 4'd0);
        blank1  = blank2  && (bcd1 == 4'd0);
        dseg0   = dp_apply(seg_lut(bcd0), dp_l_q[0]);
        dseg1   = dp_apply(blank1 ? SEG_BLANK : seg_lut(bcd1), dp_l_q[1]);
        dseg2   = dp_apply(blank2 ? SEG_BLANK : seg_lut(bcd2), dp_l_q[2]);
        dseg3   = dp_apply(blank3 ? SEG_BLANK : seg_lut(bcd3), dp_l_q[3]);
    end

    // A VALUE write always wins: it restarts the conversion from any state.
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        dp_l_d    = dp_l_q;
        ovf_d     = ovf_q;
        seg0_d    = seg0_q;
        seg1_d    = seg1_q;
        seg2_d    = seg2_q;
        seg3_d    = seg3_q;
        seg_upd_d = 1'b0;
        if (val_wr) begin
            state_d = dec_q ? S_SHIFT : S_HEX_LOAD;
            sh_d    = {20'd0, val_wdata};
            cnt_d   = 4'd15;
            dp_l_d  = dp_q;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_HEX_LOAD: begin
                    seg0_d    = dp_apply(seg_lut(val_q[3:0]),   dp_l_q[0]);
                    seg1_d    = dp_apply(seg_lut(val_q[7:4]),   dp_l_q[1]);
                    seg2_d    = dp_apply(seg_lut(val_q[11:8]),  dp_l_q[2]);
                    seg3_d    = dp_apply(seg_lut(val_q[15:12]), dp_l_q[3]);
                    seg_upd_d = 1'b1;
                    state_d   = S_IDLE;
                end
                S_SHIFT: begin
                    sh_d  = {sh_adj[34:0], 1'b0};
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd0) state_d = S_LOAD;
                end
                S_LOAD: begin
                    ovf_d = bcd_ovf;
                    if (bcd_ovf) begin
                        seg0_d = SEG_DASH;
                        seg1_d = SEG_DASH;
                        seg2_d = SEG_DASH;
                        seg3_d = SEG_DASH;
                    end else begin
                        seg0_d = dseg0;
                        seg1_d = dseg1;
                        seg2_d = dseg2;
                        seg3_d = dseg3;
                    end
                    seg_upd_d = 1'b1;
                    state_d   = S_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q   <= S_IDLE;
            val_q     <= 16'h0000;
            dec_q     <= 1'b0;
            dp_q      <= 4'h0;
            dp_l_q    <= 4'h0;
            ovf_q     <= 1'b0;
            sh_q      <= 36'd0;
            cnt_q     <= 4'd0;
            seg0_q    <= SEG_BLANK;
            seg1_q    <= SEG_BLANK;
            seg2_q    <= SEG_BLANK;
            seg3_q    <= SEG_BLANK;
            seg_upd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            val_q     <= val_d;
            dec_q     <= dec_d;
            dp_q      <= dp_d;
            dp_l_q    <= dp_l_d;
            ovf_q     <= ovf_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            seg0_q    <= seg0_d;
            seg1_q    <= seg1_d;
            seg2_q    <= seg2_d;
            seg3_q    <= seg3_d;
            seg_upd_q <= seg_upd_d;
        end
    end

endmodule

// File: tb/tb_seg7_fmt.sv
// Directed self-checking bench for seg7_fmt: register access, hex/decimal formatting, overflow,
// leading-zero blanking (SEG7_FMT_LZB_EN), decimal points, abort-on-rewrite and reset mid-conversion.
module tb_seg7_fmt;

    localparam logic [13:0] A_VAL = 14'h004C;
    localparam logic [13:0] A_CTL = 14'h004D;

    logic       mclk = 1'b0;
    logic       puc_rst;
    logic [7:0] seg_d0, seg_d1, seg_d2, seg_d3;
    logic       seg_upd, busy;

    always #5 mclk = ~mclk;

    seg7_fmt_if per_if ();

    seg7_fmt #(.BASE_ADDR(15'h0098)) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .per     (per_if),
        .seg_d0  (seg_d0),
        .seg_d1  (seg_d1),
        .seg_d2  (seg_d2),
        .seg_d3  (seg_d3),
        .seg_upd (seg_upd),
        .busy    (busy)
    );

    int n_chk = 0;
    int n_fail = 0;
    int upd_total = 0;
    int busy_total = 0;
    int upd_base, busy_base, upd_mark;
    logic [15:0] rdata;

    always @(negedge mclk) begin
        if (seg_upd) upd_total++;
        if (busy)    busy_total++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_segs(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
        chk({tag, "_d3"}, {8'h00, seg_d3}, {8'h00, e3});
        chk({tag, "_d2"}, {8'h00, seg_d2}, {8'h00, e2});
        chk({tag, "_d1"}, {8'h00, seg_d1}, {8'h00, e1});
        chk({tag, "_d0"}, {8'h00, seg_d0}, {8'h00, e0});
    endtask

    task automatic bus_wr(input logic [13:0] a, input logic [15:0] d, input logic [1:0] we);
        @(negedge mclk);
        per_if.per_addr = a;
        per_if.per_din  = d;
        per_if.per_we   = we;
        per_if.per_en   = 1'b1;
        @(posedge mclk);
        #1;
        per_if.per_en = 1'b0;
        per_if.per_we = 2'b00;
        upd_base  = upd_total;
        busy_base = busy_total;
    endtask

    task automatic bus_rd(input logic [13:0] a, output logic [15:0] d);
        @(negedge mclk);
        per_if.per_addr = a;
        per_if.per_we   = 2'b00;
        per_if.per_en   = 1'b1;
        #1;
        d = per_if.per_dout;
        per_if.per_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge mclk);
            n++;
        end
        repeat (2) @(negedge mclk);
        chk({tag, "_timeout"}, {15'd0, busy}, 16'h0000);
    endtask

    initial begin
        puc_rst         = 1'b1;
        per_if.per_addr = '0;
        per_if.per_din  = '0;
        per_if.per_we   = 2'b00;
        per_if.per_en   = 1'b0;
        repeat (3) @(negedge mclk);
        chk_segs("rst_seg", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        chk("rst_busy", {15'd0, busy}, 16'h0000);
        chk("rst_upd", {15'd0, seg_upd}, 16'h0000);
        puc_rst = 1'b0;
        bus_rd(A_CTL, rdata);
        chk("rst_ctrl", rdata, 16'h0000);
        bus_rd(A_VAL, rdata);
        chk("rst_value", rdata, 16'h0000);

        // Hex formatting
        bus_wr(A_CTL, 16'h0000, 2'b11);
        bus_wr(A_VAL, 16'h1A2F, 2'b11);
        chk("hex_busy_e0", {15'd0, busy}, 16'h0001);
        wait_idle("hex");
        chk_segs("hex", 8'hF9, 8'h88, 8'hA4, 8'h8E);
        chk("hex_upd_cnt", 16'(upd_total - upd_base), 16'd1);
        chk("hex_busy_cnt", 16'(busy_total - busy_base), 16'd1);

        // High-byte-only write merges with the held low byte
        bus_wr(A_VAL, 16'hAB00, 2'b10);
        wait_idle("merge");
        chk_segs("merge", 8'h88, 8'h83, 8'hA4, 8'h8E);
        bus_rd(A_VAL, rdata);
        chk("merge_value", rdata, 16'hAB2F);
        bus_rd(14'h004E, rdata);
        chk("unsel_read", rdata, 16'h0000);

        // CTRL write alone starts nothing
        bus_wr(A_CTL, 16'h0001, 2'b11);
        @(negedge mclk);
        chk("ctrl_no_start", {15'd0, busy}, 16'h0000);

        // Decimal 1234
        bus_wr(A_VAL, 16'h04D2, 2'b11);
        wait_idle("dec");
        chk_segs("dec", 8'hF9, 8'hA4, 8'hB0, 8'h99);
        chk("dec_busy_cnt", 16'(busy_total - busy_base), 16'd17);
        chk("dec_upd_cnt", 16'(upd_total - upd_base), 16'd1);
        bus_rd(A_CTL, rdata);
        chk("dec_ctrl", rdata, 16'h0001);

        // Leading-zero blank
        bus_wr(A_CTL, 16'h0003, 2'b11);
        bus_wr(A_VAL, 16'h0007, 2'b11);
        wait_idle("lzb");
        bus_rd(A_CTL, rdata);
`ifdef SEG7_FMT_LZB_EN
        chk_segs("lzb", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
        chk("lzb_ctrl", rdata, 16'h0003);
`else
        chk_segs("lzb", 8'hC0, 8'hC0, 8'hC0, 8'hF8);
        chk("lzb_ctrl", rdata, 16'h0001);
`endif

        // Overflow then recovery
        bus_wr(A_CTL, 16'h0001, 2'b11);
        bus_wr(A_VAL, 16'h3039, 2'b11);
        wait_idle("ovf");
        chk_segs("ovf", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        bus_rd(A_CTL, rdata);
        chk("ovf_ctrl", rdata, 16'h0201);
        bus_wr(A_VAL, 16'h002A, 2'b11);
        bus_rd(A_CTL, rdata);
        chk("ovf_clear", rdata, 16'h0101);
        wait_idle("v42");
        chk_segs("v42", 8'hC0, 8'hC0, 8'h99, 8'hA4);
        bus_rd(A_CTL, rdata);
        chk("v42_ctrl", rdata, 16'h0001);

        // Rewrite during conversion aborts the first one
        bus_wr(A_VAL, 16'h270F, 2'b11);
        upd_mark = upd_total;
        repeat (6) @(negedge mclk);
        bus_wr(A_VAL, 16'h0000, 2'b11);
        chk_segs("abort_hold", 8'hC0, 8'hC0, 8'h99, 8'hA4);
        wait_idle("abort");
        chk("abort_upd_total", 16'(upd_total - upd_mark), 16'd1);
        chk("abort_busy_cnt", 16'(busy_total - busy_base), 16'd17);
        chk_segs("abort", 8'hC0, 8'hC0, 8'hC0, 8'hC0);

        // Decimal point on digit 1
        bus_wr(A_CTL, 16'h0021, 2'b11);
        bus_wr(A_VAL, 16'h0000, 2'b11);
        wait_idle("dp");
        chk_segs("dp", 8'hC0, 8'hC0, 8'h40, 8'hC0);

        // Reset mid-conversion
        bus_wr(A_VAL, 16'h04D2, 2'b11);
        repeat (5) @(negedge mclk);
        puc_rst = 1'b1;
        #2;
        chk_segs("midrst", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        chk("midrst_busy", {15'd0, busy}, 16'h0000);
        @(negedge mclk);
        puc_rst = 1'b0;
        repeat (20) @(negedge mclk);
        chk("midrst_upd_cnt", 16'(upd_total - upd_base), 16'd0);
        bus_rd(A_CTL, rdata);
        chk("midrst_ctrl", rdata, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
